// File: rtl/acc_core.sv
// acc_core: single-accumulator processor core with a word-addressed
// request/acknowledge memory port.
//
// Each instruction is fetched in FETCH, decoded in EXEC and, for memory
// operand opcodes, completed in MEM. The HALT state is absorbing until reset.
//
// Ports:
//   clock      - single clock, all state changes on its rising edge
//   reset_n    - asynchronous active-low reset
//   mem_req    - memory request valid (FETCH and MEM states only)
//   mem_we     - 1 = write, 0 = read; valid while mem_req = 1
//   mem_addr   - word address (pc in FETCH, operand address in MEM)
//   mem_wdata  - write data (always the accumulator)
//   mem_rdata  - read data, used only when mem_ack = 1
//   mem_ack    - completes the outstanding request in the same cycle
//   pc         - program counter
//   acc        - accumulator
//   flags      - {N, Z}, updated by CMP only
//   retire     - one-cycle pulse per completed instruction
//   halted     - core stopped by HALT
module acc_core #(
    parameter int DW = 16,
    parameter int AW = DW - 4
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [1:0]    flags,
    output logic          retire,
    output logic          halted
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_LD   = 4'h0,
        OP_ADD  = 4'h1,
        OP_JMP  = 4'h2,
        OP_ST   = 4'h3,
        OP_CMP  = 4'h4,
        OP_JEQ  = 4'h5,
        OP_SUB  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_XOR  = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_JLT  = 4'hC,
        OP_JNE  = 4'hD,
        OP_LDI  = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    state_t        state;
    logic [DW-1:0] ir;
    op_t           op;
    logic [AW-1:0] operand;
    logic          mem_op;

    assign op      = op_t'(ir[DW-1:DW-4]);
    assign operand = ir[AW-1:0];

    always_comb begin
        mem_op = op inside {OP_LD, OP_ADD, OP_ST, OP_CMP, OP_SUB,
                            OP_AND, OP_OR, OP_XOR};
    end

    // Memory port is decoded from registered state only; reset_n gates the
    // request so it drops the instant reset is asserted, even mid-transfer.
    assign mem_req   = reset_n && ((state == FETCH) || (state == MEM));
    assign mem_we    = (state == MEM) && (op == OP_ST);
    assign mem_addr  = (state == MEM) ? operand : pc;
    assign mem_wdata = acc;

    // Register/jump/HALT opcodes finish in EXEC; memory opcodes finish on the
    // acknowledge of their MEM access.
    assign retire = reset_n && (((state == EXEC) && !mem_op) ||
                                ((state == MEM) && mem_ack));
    assign halted = (state == HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            pc    <= '0;
            acc   <= '0;
            flags <= '0;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + AW'(1);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_JMP:  pc <= operand;
                        OP_JEQ:  if (flags[0]) pc <= operand;
                        OP_JLT:  if (flags[1]) pc <= operand;
                        OP_JNE:  if (!flags[0]) pc <= operand;
                        OP_SHL:  acc <= {acc[DW-2:0], 1'b0};
                        OP_SHR:  acc <= {1'b0, acc[DW-1:1]};
                        OP_LDI:  acc <= DW'(operand);
                        OP_HALT: state <= HALT;
                        default: state <= MEM;
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        state <= FETCH;
                        case (op)
                            OP_LD:   acc <= mem_rdata;
                            OP_ADD:  acc <= acc + mem_rdata;
                            OP_SUB:  acc <= acc - mem_rdata;
                            OP_AND:  acc <= acc & mem_rdata;
                            OP_OR:   acc <= acc | mem_rdata;
                            OP_XOR:  acc <= acc ^ mem_rdata;
                            OP_CMP:  flags <= {acc < mem_rdata, acc == mem_rdata};
                            // ST: the write is carried by the acknowledged request
                            default: ;
                        endcase
                    end
                end
                HALT: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: self-checking bench for acc_core (DW = 16).
// A behavioural memory responder serves the core; an instruction-level
// reference model is stepped on every retire pulse and compared against the
// core's architectural state and per-instruction cycle count.
module tb_acc_core;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int MSZ = 1 << AW;

    logic          clock;
    logic          reset_n;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [1:0]    flags;
    logic          retire;
    logic          halted;

    acc_core #(.DW(DW), .AW(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .acc       (acc),
        .flags     (flags),
        .retire    (retire),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory responder ----------------
    logic [DW-1:0] mem [MSZ];
    logic [DW-1:0] img [MSZ];
    bit            load_tog, load_seen;
    bit            rand_wait, junk_ack;
    int unsigned   wait_cfg, need, waited, wait_total, write_count;

    assign mem_ack   = mem_req ? (waited >= need) : junk_ack;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (load_tog != load_seen) begin
            mem = img;
            load_seen = load_tog;
        end
        if (!reset_n) begin
            waited <= 0;
            need   <= rand_wait ? $urandom_range(0, 2) : wait_cfg;
        end else if (mem_req && !mem_ack) begin
            waited     <= waited + 1;
            wait_total <= wait_total + 1;
        end else if (mem_req) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                write_count <= write_count + 1;
            end
            waited <= 0;
            need   <= rand_wait ? $urandom_range(0, 2) : wait_cfg;
        end
        junk_ack <= rand_wait && ($urandom_range(0, 1) == 1);
    end

    // ---------------- checking ----------------
    int unsigned n_checks, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [DW-1:0] ref_mem [MSZ];
    int unsigned   rpc, racc, rn, rz;
    bit            rhalt;

    task automatic model_step(output int unsigned base);
        int unsigned ins, op, c, mv;
        ins  = ref_mem[rpc];
        op   = ins / 4096;
        c    = ins % 4096;
        mv   = ref_mem[c];
        rpc  = (rpc + 1) % 4096;
        base = 2;
        case (op)
            0:  begin racc = mv;                          base = 3; end
            1:  begin racc = (racc + mv) % 65536;         base = 3; end
            2:  rpc = c;
            3:  begin ref_mem[c] = DW'(racc);             base = 3; end
            4:  begin
                    rn = (racc < mv) ? 1 : 0;
                    rz = (racc == mv) ? 1 : 0;
                    base = 3;
                end
            5:  if (rz == 1) rpc = c;
            6:  begin racc = (racc + 65536 - mv) % 65536; base = 3; end
            7:  begin racc = racc & mv;                   base = 3; end
            8:  begin racc = racc | mv;                   base = 3; end
            9:  begin racc = racc ^ mv;                   base = 3; end
            10: racc = (racc * 2) % 65536;
            11: racc = racc / 2;
            12: if (rn == 1) rpc = c;
            13: if (rz == 0) rpc = c;
            14: racc = c;
            default: rhalt = 1'b1;
        endcase
    endtask

    // Hold reset for two cycles, load img into memory and model, check the
    // reset state, then release on a falling edge (first fetch cycle).
    task automatic do_reset();
        reset_n  = 1'b0;
        load_tog = ~load_tog;
        ref_mem  = img;
        rpc = 0; racc = 0; rn = 0; rz = 0; rhalt = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pc",      32'(pc),      32'h0);
        check("rst_acc",     32'(acc),     32'h0);
        check("rst_flags",   32'(flags),   32'h0);
        check("rst_retire",  32'(retire),  32'h0);
        check("rst_halted",  32'(halted),  32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        reset_n = 1'b1;
    endtask

    // Lockstep run: on each retire, step the model, check the instruction's
    // cycle count, then check architectural state after the completing edge.
    task automatic run_program(input int unsigned max_instr,
                               output int unsigned total, output int unsigned rets);
        int unsigned cyc, base, mark;
        total = 0;
        rets  = 0;
        cyc   = 1;
        mark  = wait_total;
        while (rets < max_instr && !rhalt) begin
            if (retire) begin
                model_step(base);
                check("instr_cycles", cyc, base + (wait_total - mark));
                total += cyc;
                rets++;
                mark = wait_total;
                @(negedge clock);
                check("pc",     32'(pc),     rpc);
                check("acc",    32'(acc),    racc);
                check("flags",  32'(flags),  rn * 2 + rz);
                check("halted", 32'(halted), 32'(rhalt));
                cyc = 1;
            end else if (cyc >= 16) begin
                check("instr_timeout", 32'(retire), 32'h1);
                return;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
    endtask

    task automatic clear_img();
        for (int unsigned i = 0; i < MSZ; i++) img[i] = '0;
    endtask

    int unsigned   tot, rets, w0, held, ret_cyc, n, diffs;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [3:0]    rop;
    logic [AW-1:0] rc;

    initial begin
        rand_wait = 1'b0;
        wait_cfg  = 0;

        // Load/add/store/halt program: cycle count to halt and retire count.
        clear_img();
        img[0] = 16'h0010; img[1] = 16'h1011; img[2] = 16'h3012; img[3] = 16'hF000;
        img[16'h10] = 16'd5; img[16'h11] = 16'd3;
        do_reset();
        run_program(10, tot, rets);
        check("p1_store",   32'(mem[12'h012]), 32'h0008);
        check("p1_acc",     32'(acc),          32'h0008);
        check("p1_halted",  32'(halted),       32'h1);
        check("p1_cycles",  tot,               32'd11);
        check("p1_retires", rets,              32'd4);
        repeat (3) @(negedge clock);
        check("halt_stays",  32'(halted),  32'h1);
        check("halt_no_req", 32'(mem_req), 32'h0);
        check("halt_pc",     32'(pc),      32'h4);

        // Subtract wraps modulo 2^16; flags set by the earlier CMP survive.
        clear_img();
        img[0] = 16'hE000; img[1] = 16'h4010; img[2] = 16'h0010;
        img[3] = 16'h6011; img[4] = 16'hF000;
        img[16'h10] = 16'd0; img[16'h11] = 16'd1;
        do_reset();
        run_program(10, tot, rets);
        check("sub_wrap_acc", 32'(acc),   32'hFFFF);
        check("sub_flags",    32'(flags), 32'h1);

        // CMP equal then JEQ taken; CMP less-than then JEQ not taken.
        for (int unsigned k = 0; k < 2; k++) begin
            clear_img();
            img[0] = 16'hE005; img[1] = 16'h4010; img[2] = 16'h5020;
            img[16'h10] = (k == 0) ? 16'd5 : 16'd9;
            do_reset();
            run_program(3, tot, rets);
            check("jeq_pc",    32'(pc),    (k == 0) ? 32'h020 : 32'h003);
            check("jeq_flags", 32'(flags), (k == 0) ? 32'h1 : 32'h2);
        end

        // Jump to the top word; pc wraps to 0 for the next fetch.
        clear_img();
        img[0] = 16'h2FFF; img[12'hFFF] = 16'hE007;
        do_reset();
        run_program(2, tot, rets);
        check("wrap_acc",  32'(acc),      32'h7);
        check("wrap_addr", 32'(mem_addr), 32'h0);
        check("wrap_req",  32'(mem_req),  32'h1);

        // Store with three wait cycles on every request.
        wait_cfg = 3;
        clear_img();
        img[0] = 16'hE0AB; img[1] = 16'h3040; img[16'h40] = 16'h5555;
        do_reset();
        run_program(1, tot, rets);
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("st_seen", 32'(mem_we), 32'h1);
        a0 = mem_addr; d0 = mem_wdata; w0 = write_count; held = 0; ret_cyc = 0;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (mem_req && mem_we && mem_addr == a0 && mem_wdata == d0) held++;
            if (retire) ret_cyc = i;
            if (i < 4) @(negedge clock);
        end
        check("st_held",      held,           32'd4);
        check("st_addr",      32'(a0),        32'h040);
        check("st_data",      32'(d0),        32'h00AB);
        check("st_retire_at", ret_cyc,        32'd4);
        @(negedge clock);
        check("st_writes",    write_count - w0, 32'd1);
        check("st_mem",       32'(mem[12'h040]), 32'h00AB);
        check("st_next_we",   32'(mem_we),    32'h0);
        wait_cfg = 0;

        // Reset asserted during the MEM cycle of a store.
        clear_img();
        img[0] = 16'hE055; img[1] = 16'h3030; img[16'h30] = 16'h1234;
        do_reset();
        run_program(1, tot, rets);
        repeat (2) @(negedge clock);
        check("rmid_in_store", 32'(mem_we), 32'h1);
        w0 = write_count;
        reset_n = 1'b0;
        #1;
        check("rmid_req_drop", 32'(mem_req), 32'h0);
        @(negedge clock);
        check("rmid_target", 32'(mem[12'h030]), 32'h1234);
        check("rmid_writes", write_count - w0,   32'd0);
        check("rmid_pc",     32'(pc),            32'h0);
        check("rmid_acc",    32'(acc),           32'h0);
        reset_n = 1'b1;
        #1;
        check("rmid_fetch_addr", 32'(mem_addr), 32'h0);
        check("rmid_fetch_req",  32'(mem_req),  32'h1);
        check("rmid_fetch_we",   32'(mem_we),   32'h0);
        @(negedge clock);

        // Random programs with random wait states and stray acknowledges.
        rand_wait = 1'b1;
        for (int unsigned p = 0; p < 15; p++) begin
            clear_img();
            for (int unsigned i = 0; i < 128; i++) begin
                rop = 4'($urandom_range(0, 15));
                if (rop == 4'hF && $urandom_range(0, 7) != 0) rop = 4'($urandom_range(0, 14));
                rc = AW'($urandom_range(0, 127));
                img[i] = {rop, rc};
            end
            do_reset();
            run_program(120, tot, rets);
            diffs = 0;
            for (int unsigned i = 0; i < 256; i++)
                if (mem[i] !== ref_mem[i]) diffs++;
            check("rand_mem", diffs, 32'd0);
            if (rhalt) begin
                repeat (2) @(negedge clock);
                check("rand_halt_req", 32'(mem_req), 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
